// File: rtl/cernbe_axi4lite_master_pkg.sv
// Shared definitions for the CERN-BE to AXI4-Lite bridge.
//   state_t          : bridge FSM states
//   AXI_RESP_*       : AXI4-Lite xRESP encodings
//   AXI_PROT_DEFAULT : AxPROT driven on every request (unprivileged, secure, data)
//   AXI_WSTRB_ALL    : full-word write strobe
package cernbe_axi4lite_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = '0;
  localparam logic [3:0] AXI_WSTRB_ALL    = '1;

endpackage

// File: rtl/cernbe_axi4lite_master_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) with a 32-bit data path.
//   master modport : initiator side (drives valids, addresses, data, bready/rready)
//   slave  modport : target side (drives readies, responses, read data)
interface cernbe_axi4lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;

  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;

  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/cernbe_axi4lite_master.sv
// CERN-BE submap responder bridging onto an AXI4-Lite initiator port.
// Each VMEWrMem_i / VMERdMem_i strobe becomes one AXI4-Lite write / read;
// completion is a one-cycle VMEWrDone_o / VMERdDone_o pulse with the error
// flag taken from xRESP[1]. One AXI transaction is outstanding at a time,
// writes win over reads when both are waiting.
//   aclk, areset_n     : clock, asynchronous active-low reset
//   VMEAddr_i          : word address (AXI byte address = {VMEAddr_i, 2'b00})
//   VMEWrData_i        : write data, captured with VMEWrMem_i
//   VMERdMem_i/WrMem_i : single-cycle read / write strobes
//   VMERdData_o        : last read data, held until the next read completes
//   VMERd/WrDone_o     : completion pulses
//   VMERd/WrError_o    : error flags, only ever high together with their Done
//   axi                : AXI4-Lite initiator (master modport); all outputs registered
module cernbe_axi4lite_master
  import cernbe_axi4lite_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [ADDR_WIDTH-3:0] VMEAddr_i,
  input  logic [31:0]           VMEWrData_i,
  input  logic                  VMERdMem_i,
  input  logic                  VMEWrMem_i,
  output logic [31:0]           VMERdData_o,
  output logic                  VMERdDone_o,
  output logic                  VMEWrDone_o,
  output logic                  VMERdError_o,
  output logic                  VMEWrError_o,
  cernbe_axi4lite_master_if.master axi
);

  typedef struct packed {
    logic                  wr_pend;
    logic                  rd_pend;
    logic [ADDR_WIDTH-3:0] wr_addr;
    logic [ADDR_WIDTH-3:0] rd_addr;
    logic [31:0]           wr_data;
    logic [31:0]           rd_data;
    logic                  awvalid;
    logic                  wvalid;
    logic                  bready;
    logic                  arvalid;
    logic                  rready;
    logic                  wr_done;
    logic                  wr_err;
    logic                  rd_done;
    logic                  rd_err;
  } regs_t;

  state_t state_q, state_d;
  regs_t  r_q, r_d;
  logic   wr_acc, rd_acc;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    r_d.wr_done = 1'b0;
    r_d.wr_err  = 1'b0;
    r_d.rd_done = 1'b0;
    r_d.rd_err  = 1'b0;

    // A strobe is dropped while the same kind is already pending or on the bus.
    wr_acc = VMEWrMem_i && !r_q.wr_pend && !(state_q inside {ST_WR_REQ, ST_WR_RESP});
    rd_acc = VMERdMem_i && !r_q.rd_pend && !(state_q inside {ST_RD_REQ, ST_RD_RESP});

    if (wr_acc) begin
      r_d.wr_pend = 1'b1;
      r_d.wr_addr = VMEAddr_i;
      r_d.wr_data = VMEWrData_i;
    end
    if (rd_acc) begin
      r_d.rd_pend = 1'b1;
      r_d.rd_addr = VMEAddr_i;
    end

    case (state_q)
      // Decisions use r_d pend flags so a strobe arriving in IDLE launches
      // its request on the very next edge instead of waiting a cycle.
      ST_IDLE: begin
        if (r_d.wr_pend) begin
          state_d     = ST_WR_REQ;
          r_d.wr_pend = 1'b0;
          r_d.awvalid = 1'b1;
          r_d.wvalid  = 1'b1;
        end else if (r_d.rd_pend) begin
          state_d     = ST_RD_REQ;
          r_d.rd_pend = 1'b0;
          r_d.arvalid = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (axi.awready) r_d.awvalid = 1'b0;
        if (axi.wready)  r_d.wvalid  = 1'b0;
        if (!r_d.awvalid && !r_d.wvalid) begin
          state_d    = ST_WR_RESP;
          r_d.bready = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (axi.bvalid) begin
          state_d     = ST_IDLE;
          r_d.bready  = 1'b0;
          r_d.wr_done = 1'b1;
          r_d.wr_err  = axi.bresp[1];
        end
      end
      ST_RD_REQ: begin
        if (axi.arready) begin
          state_d     = ST_RD_RESP;
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
        end
      end
      ST_RD_RESP: begin
        if (axi.rvalid) begin
          state_d     = ST_IDLE;
          r_d.rready  = 1'b0;
          r_d.rd_data = axi.rdata;
          r_d.rd_done = 1'b1;
          r_d.rd_err  = axi.rresp[1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign axi.awvalid = r_q.awvalid;
  assign axi.awaddr  = {r_q.wr_addr, 2'b00};
  assign axi.awprot  = AXI_PROT_DEFAULT;
  assign axi.wvalid  = r_q.wvalid;
  assign axi.wdata   = r_q.wr_data;
  assign axi.wstrb   = AXI_WSTRB_ALL;
  assign axi.bready  = r_q.bready;
  assign axi.arvalid = r_q.arvalid;
  assign axi.araddr  = {r_q.rd_addr, 2'b00};
  assign axi.arprot  = AXI_PROT_DEFAULT;
  assign axi.rready  = r_q.rready;

  assign VMERdData_o  = r_q.rd_data;
  assign VMERdDone_o  = r_q.rd_done;
  assign VMEWrDone_o  = r_q.wr_done;
  assign VMERdError_o = r_q.rd_err;
  assign VMEWrError_o = r_q.wr_err;

  // Only xRESP[1] distinguishes success from failure.
  logic unused_resp_lsbs;
  assign unused_resp_lsbs = axi.bresp[0] ^ axi.rresp[0];

endmodule

// File: tb/tb_cernbe_axi4lite_master.sv
// Bench for cernbe_axi4lite_master: directed scenarios followed by randomized
// write/read traffic against a behavioural AXI4-Lite slave with configurable
// wait states and responses; expected read data comes from a word-array model
// of what the CERN-BE side has written.
module tb_cernbe_axi4lite_master;
  import cernbe_axi4lite_master_pkg::*;

  localparam int unsigned AW = 32;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic [AW-3:0] VMEAddr_i;
  logic [31:0]   VMEWrData_i;
  logic          VMERdMem_i;
  logic          VMEWrMem_i;
  logic [31:0]   VMERdData_o;
  logic          VMERdDone_o;
  logic          VMEWrDone_o;
  logic          VMERdError_o;
  logic          VMEWrError_o;

  cernbe_axi4lite_master_if #(.ADDR_WIDTH(AW)) axi ();

  cernbe_axi4lite_master #(.ADDR_WIDTH(AW)) u_dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .VMEAddr_i   (VMEAddr_i),
    .VMEWrData_i (VMEWrData_i),
    .VMERdMem_i  (VMERdMem_i),
    .VMEWrMem_i  (VMEWrMem_i),
    .VMERdData_o (VMERdData_o),
    .VMERdDone_o (VMERdDone_o),
    .VMEWrDone_o (VMEWrDone_o),
    .VMERdError_o(VMERdError_o),
    .VMEWrError_o(VMEWrError_o),
    .axi         (axi)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  // Slave configuration, set by the stimulus.
  int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = AXI_RESP_OKAY;
  logic [1:0]  r_resp_cfg = AXI_RESP_OKAY;
  bit          r_force = 1'b0;
  logic [31:0] r_force_data = '0;

  // Handshake bookkeeping (monitor) and slave storage.
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [31:0] last_wdata = '0;
  bit   [31:0] mem [0:63];
  int          wr_done_cnt = 0, rd_done_cnt = 0;
  int unsigned aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

  // Reference model of word contents as seen from the CERN-BE side.
  logic [31:0] ref_mem [0:63];

  // Unwritten slave words read back as a per-address pattern; mem holds the
  // XOR against that pattern so its zero initial value means "never written".
  function automatic logic [31:0] dflt(input logic [5:0] i);
    return {16'h5EED, 10'h000, i};
  endfunction

  always @(posedge aclk) begin
    if (!areset_n) begin
      aw_hs <= 0; w_hs <= 0; b_hs <= 0; ar_hs <= 0; r_hs <= 0;
    end else begin
      if (axi.awvalid && axi.awready) begin aw_hs <= aw_hs + 1; last_awaddr <= axi.awaddr; end
      if (axi.wvalid && axi.wready) begin w_hs <= w_hs + 1; last_wdata <= axi.wdata; end
      if (axi.bvalid && axi.bready) begin
        b_hs <= b_hs + 1;
        mem[last_awaddr[7:2]] <= last_wdata ^ dflt(last_awaddr[7:2]);
      end
      if (axi.arvalid && axi.arready) begin ar_hs <= ar_hs + 1; last_araddr <= axi.araddr; end
      if (axi.rvalid && axi.rready) r_hs <= r_hs + 1;
    end
  end

  always @(negedge aclk) begin
    if (VMEWrDone_o) wr_done_cnt <= wr_done_cnt + 1;
    if (VMERdDone_o) rd_done_cnt <= rd_done_cnt + 1;
  end

  always @(negedge aclk) begin
    if (!areset_n) begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= '0;
      axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rresp <= '0; axi.rdata <= '0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
    end else begin
      if (!axi.awvalid) begin axi.awready <= 1'b0; aw_wait <= 0; end
      else if (!axi.awready) begin
        if (aw_wait >= aw_delay) axi.awready <= 1'b1; else aw_wait <= aw_wait + 1;
      end
      if (!axi.wvalid) begin axi.wready <= 1'b0; w_wait <= 0; end
      else if (!axi.wready) begin
        if (w_wait >= w_delay) axi.wready <= 1'b1; else w_wait <= w_wait + 1;
      end
      if (!axi.arvalid) begin axi.arready <= 1'b0; ar_wait <= 0; end
      else if (!axi.arready) begin
        if (ar_wait >= ar_delay) axi.arready <= 1'b1; else ar_wait <= ar_wait + 1;
      end
      if (!(b_hs < aw_hs && b_hs < w_hs)) begin axi.bvalid <= 1'b0; b_wait <= 0; end
      else if (!axi.bvalid) begin
        if (b_wait >= b_delay) begin axi.bvalid <= 1'b1; axi.bresp <= b_resp_cfg; end
        else b_wait <= b_wait + 1;
      end
      if (!(r_hs < ar_hs)) begin axi.rvalid <= 1'b0; r_wait <= 0; end
      else if (!axi.rvalid) begin
        if (r_wait >= r_delay) begin
          axi.rvalid <= 1'b1;
          axi.rresp  <= r_resp_cfg;
          axi.rdata  <= r_force ? r_force_data
                                : (mem[last_araddr[7:2]] ^ dflt(last_araddr[7:2]));
        end else r_wait <= r_wait + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [AW-3:0] a, input logic [31:0] d);
    VMEAddr_i = a; VMEWrData_i = d; VMEWrMem_i = 1'b1;
    tick();
    VMEWrMem_i = 1'b0;
  endtask

  task automatic do_read(input logic [AW-3:0] a);
    VMEAddr_i = a; VMERdMem_i = 1'b1;
    tick();
    VMERdMem_i = 1'b0;
  endtask

  task automatic do_both(input logic [AW-3:0] a, input logic [31:0] d);
    VMEAddr_i = a; VMEWrData_i = d; VMEWrMem_i = 1'b1; VMERdMem_i = 1'b1;
    tick();
    VMEWrMem_i = 1'b0; VMERdMem_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit is_wr, input int budget);
    int n = 0;
    while (!(is_wr ? VMEWrDone_o : VMERdDone_o) && n < budget) begin
      tick();
      n++;
    end
    check(tag, {63'd0, is_wr ? VMEWrDone_o : VMERdDone_o}, 64'd1);
  endtask

  function automatic logic [1:0] pick_resp();
    case ($urandom_range(0, 3))
      0:       return AXI_RESP_OKAY;
      1:       return AXI_RESP_EXOKAY;
      2:       return AXI_RESP_SLVERR;
      default: return AXI_RESP_DECERR;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_aw, base_w, base_wd, base_rd;
    logic [AW-3:0] a, a2;
    logic [31:0]   d;
    logic [1:0]    bresp_exp, rresp_exp;

    areset_n = 1'b0;
    VMEAddr_i = '0; VMEWrData_i = '0; VMERdMem_i = 1'b0; VMEWrMem_i = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = dflt(6'(i));
    repeat (3) tick();

    // Reset state and constant outputs
    check("rst_awvalid", {63'd0, axi.awvalid}, 64'd0);
    check("rst_wvalid",  {63'd0, axi.wvalid},  64'd0);
    check("rst_arvalid", {63'd0, axi.arvalid}, 64'd0);
    check("rst_bready",  {63'd0, axi.bready},  64'd0);
    check("rst_rready",  {63'd0, axi.rready},  64'd0);
    check("rst_done",    {62'd0, VMEWrDone_o, VMERdDone_o}, 64'd0);
    check("rst_err",     {62'd0, VMEWrError_o, VMERdError_o}, 64'd0);
    check("rst_rddata",  {32'd0, VMERdData_o}, 64'd0);
    check("wstrb",       {60'd0, axi.wstrb}, 64'hF);
    check("prot",        {58'd0, axi.awprot, axi.arprot}, 64'd0);
    areset_n = 1'b1;
    tick();

    // 1: zero-wait write, exact latency
    b_resp_cfg = AXI_RESP_OKAY;
    do_write(30'h10, 32'h1234_5678);
    ref_mem[6'h10] = 32'h1234_5678;
    check("t1_valids_c1", {62'd0, axi.awvalid, axi.wvalid}, 64'd3);
    check("t1_awaddr",    {32'd0, axi.awaddr}, 64'h40);
    check("t1_wdata",     {32'd0, axi.wdata}, 64'h1234_5678);
    check("t1_arvalid",   {63'd0, axi.arvalid}, 64'd0);
    tick();
    check("t1_c2",        {61'd0, axi.awvalid, axi.wvalid, axi.bready}, 64'd1);
    check("t1_done_c2",   {63'd0, VMEWrDone_o}, 64'd0);
    tick();
    check("t1_done_c3",   {62'd0, VMEWrDone_o, VMEWrError_o}, 64'd2);
    tick();
    check("t1_done_c4",   {62'd0, VMEWrDone_o, VMEWrError_o}, 64'd0);

    // 2: read with SLVERR
    r_force = 1'b1; r_force_data = 32'hDEAD_BEEF; r_resp_cfg = AXI_RESP_SLVERR;
    do_read(30'h3);
    check("t2_arvalid_c1", {63'd0, axi.arvalid}, 64'd1);
    check("t2_araddr",     {32'd0, axi.araddr}, 64'h0C);
    tick();
    check("t2_c2",         {62'd0, axi.arvalid, axi.rready}, 64'd1);
    tick();
    check("t2_done_c3",    {62'd0, VMERdDone_o, VMERdError_o}, 64'd3);
    check("t2_rddata",     {32'd0, VMERdData_o}, 64'hDEAD_BEEF);
    tick();
    check("t2_done_c4",    {62'd0, VMERdDone_o, VMERdError_o}, 64'd0);
    check("t2_rddata_hold", {32'd0, VMERdData_o}, 64'hDEAD_BEEF);
    r_force = 1'b0; r_resp_cfg = AXI_RESP_OKAY;

    // 3: simultaneous strobes -> write first, read sees the written word
    base_wd = wr_done_cnt; base_rd = rd_done_cnt;
    do_both(30'h21, 32'hA5A5_0033);
    ref_mem[6'h21] = 32'hA5A5_0033;
    check("t3_c1", {62'd0, axi.awvalid, axi.arvalid}, 64'd2);
    tick(); tick();
    check("t3_c3", {61'd0, VMEWrDone_o, VMERdDone_o, axi.arvalid}, 64'd4);
    tick();
    check("t3_arvalid_c4", {63'd0, axi.arvalid}, 64'd1);
    check("t3_araddr",     {32'd0, axi.araddr}, 64'h84);
    wait_done("t3_rd_done", 1'b0, 20);
    check("t3_rddata", {32'd0, VMERdData_o}, {32'd0, ref_mem[6'h21]});
    repeat (3) tick();
    check("t3_done_counts", {32'(wr_done_cnt - base_wd), 32'(rd_done_cnt - base_rd)},
          {32'd1, 32'd1});

    // 4: AW stalled, W immediate
    aw_delay = 5; base_aw = aw_hs; base_wd = wr_done_cnt;
    do_write(30'h05, 32'h0BAD_F00D);
    ref_mem[6'h05] = 32'h0BAD_F00D;
    check("t4_c1", {62'd0, axi.awvalid, axi.wvalid}, 64'd3);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("t4_aw_hold", {31'd0, axi.awvalid, axi.wvalid, axi.awaddr}, {31'd0, 1'b1, 1'b0, 32'h14});
    end
    tick();
    check("t4_c7", {62'd0, axi.awvalid, axi.bready}, 64'd1);
    tick();
    check("t4_done_c8", {63'd0, VMEWrDone_o}, 64'd1);
    repeat (3) tick();
    check("t4_counts", {32'(aw_hs - base_aw), 32'(wr_done_cnt - base_wd)}, {32'd1, 32'd1});
    aw_delay = 0;

    // 5: second write strobe while waiting for B is dropped
    b_delay = 3; base_aw = aw_hs; base_w = w_hs; base_wd = wr_done_cnt;
    do_write(30'h08, 32'h1111_1111);
    ref_mem[6'h08] = 32'h1111_1111;
    tick();
    do_write(30'h09, 32'h2222_2222);
    wait_done("t5_wr_done", 1'b1, 20);
    repeat (10) tick();
    check("t5_counts", {16'(aw_hs - base_aw), 16'(w_hs - base_w), 32'(wr_done_cnt - base_wd)},
          {16'd1, 16'd1, 32'd1});
    check("t5_awaddr", {32'd0, last_awaddr}, 64'h20);
    check("t5_mem9_untouched", {32'd0, mem[9] ^ dflt(6'd9)}, {32'd0, ref_mem[9]});
    b_delay = 0;

    // 6: reset while waiting for R
    r_delay = 10; base_rd = rd_done_cnt;
    do_read(30'h07);
    tick(); tick(); tick();
    check("t6_in_rd_resp", {63'd0, axi.rready}, 64'd1);
    areset_n = 1'b0;
    #1;
    check("t6_async_clear", {60'd0, axi.arvalid, axi.rready, VMERdDone_o, VMEWrDone_o}, 64'd0);
    check("t6_rddata_clear", {32'd0, VMERdData_o}, 64'd0);
    repeat (3) tick();
    areset_n = 1'b1;
    repeat (12) tick();
    check("t6_no_done", {32'd0, 32'(rd_done_cnt - base_rd)}, 64'd0);
    check("t6_idle", {62'd0, axi.arvalid, axi.rready}, 64'd0);
    r_delay = 0;
    do_read(30'h21);
    wait_done("t6_recover_done", 1'b0, 20);
    check("t6_recover_data", {32'd0, VMERdData_o}, {32'd0, ref_mem[6'h21]});
    tick();

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      b_resp_cfg = pick_resp(); r_resp_cfg = pick_resp();
      bresp_exp = b_resp_cfg; rresp_exp = r_resp_cfg;
      a  = 30'($urandom_range(0, 63));
      a2 = 30'($urandom_range(0, 63));
      d  = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          do_write(a, d);
          ref_mem[a[5:0]] = d;
          wait_done("rnd_wr_done", 1'b1, 40);
          check("rnd_wr_err", {63'd0, VMEWrError_o}, {63'd0, bresp_exp[1]});
          tick();
          check("rnd_wr_pulse", {62'd0, VMEWrDone_o, VMEWrError_o}, 64'd0);
        end
        1: begin
          do_read(a);
          wait_done("rnd_rd_done", 1'b0, 40);
          check("rnd_rd_data", {31'd0, VMERdError_o, VMERdData_o},
                {31'd0, rresp_exp[1], ref_mem[a[5:0]]});
          tick();
          check("rnd_rd_pulse", {62'd0, VMERdDone_o, VMERdError_o}, 64'd0);
        end
        default: begin
          do_both(a, d);
          ref_mem[a[5:0]] = d;
          wait_done("rnd_both_wr_done", 1'b1, 40);
          check("rnd_both_order", {62'd0, VMERdDone_o, VMEWrError_o}, {62'd0, 1'b0, bresp_exp[1]});
          wait_done("rnd_both_rd_done", 1'b0, 40);
          check("rnd_both_rd_data", {31'd0, VMERdError_o, VMERdData_o},
                {31'd0, rresp_exp[1], ref_mem[a[5:0]]});
          tick();
        end
      endcase
      if (a2[0]) tick();
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
